// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
//   sa_state_t : controller state encoding (IDLE, RUN, DONE)
//   cnt_width  : bit-counter width for a given operand width (at least 1)
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the only arithmetic in the serial adder datapath.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. Accepts two WIDTH-bit operands plus carry-in over a
// valid/ready handshake, adds them LSB first through one full_adder, and presents the
// WIDTH-bit sum and carry-out over a second valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   op_a, op_b, cin     : operands, sampled on the input handshake
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   sum, cout           : result, held until the next operand load
//   busy                : high while an operation is in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("serial_add_ctrl: WIDTH must be in 1..64");
  end

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = op_a;
          b_sh_d   = op_b;
          carry_d  = cin;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        sum_sh_d = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = fa_sum;
        carry_d  = fa_cout;
        if (cnt_q == CNT_LAST) begin
          // Counter is left at its last value so it never wraps.
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH = 8, 1 and 16.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8 instance
  logic iv8, ir8, ci8, ov8, or8, co8, bz8;
  logic [7:0] a8, b8, s8;
  // WIDTH = 1 instance
  logic iv1, ir1, ci1, ov1, or1, co1, bz1;
  logic [0:0] a1, b1, s1;
  // WIDTH = 16 instance
  logic iv16, ir16, ci16, ov16, or16, co16, bz16;
  logic [15:0] a16, b16, s16;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op_a(a8), .op_b(b8),
    .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
  );
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op_a(a1), .op_b(b1),
    .cin(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
  );
  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
    .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic c);
    case (w)
      1: begin iv1 = v; a1 = a[0:0]; b1 = b[0:0]; ci1 = c; end
      16: begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; ci16 = c; end
      default: begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; ci8 = c; end
    endcase
  endtask

  task automatic set_rdy(input int w, input logic r);
    case (w)
      1: or1 = r;
      16: or16 = r;
      default: or8 = r;
    endcase
  endtask

  function automatic logic get_ir(input int w);
    case (w) 1: return ir1; 16: return ir16; default: return ir8; endcase
  endfunction
  function automatic logic get_ov(input int w);
    case (w) 1: return ov1; 16: return ov16; default: return ov8; endcase
  endfunction
  function automatic logic get_busy(input int w);
    case (w) 1: return bz1; 16: return bz16; default: return bz8; endcase
  endfunction
  function automatic logic [63:0] get_sum(input int w);
    case (w) 1: return 64'(s1); 16: return 64'(s16); default: return 64'(s8); endcase
  endfunction
  function automatic logic get_cout(input int w);
    case (w) 1: return co1; 16: return co16; default: return co8; endcase
  endfunction

  // Reference: plain integer addition of the masked operands.
  function automatic logic [64:0] ref_add(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c);
    logic [64:0] m;
    m = (65'd1 << w) - 65'd1;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + 65'(c);
  endfunction

  // One full operation. With hold_rdy, out_ready is high from before the accept; otherwise
  // the result is backpressured for wait_n cycles, with a rejected in_valid pulse inside.
  task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic [63:0] exp_sum, input logic exp_cout, input logic hold_rdy,
                       input int wait_n);
    int lat;
    drive(w, 1'b1, a, b, c);
    set_rdy(w, hold_rdy);
    check($sformatf("w%0d in_ready before accept", w), 64'(get_ir(w)), 64'd1);
    tick();
    // Scramble operands after the accepting edge; the result must not change.
    drive(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    check($sformatf("w%0d busy after accept", w), 64'(get_busy(w)), 64'd1);
    check($sformatf("w%0d in_ready after accept", w), 64'(get_ir(w)), 64'd0);
    lat = 0;
    while (!get_ov(w) && lat < w + 10) begin
      tick();
      lat++;
    end
    check($sformatf("w%0d latency", w), 64'(lat), 64'(w));
    check($sformatf("w%0d sum", w), get_sum(w), exp_sum);
    check($sformatf("w%0d cout", w), 64'(get_cout(w)), 64'(exp_cout));
    if (!hold_rdy) begin
      for (int i = 0; i < wait_n; i++) begin
        if (i == 1) drive(w, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        tick();
        if (i == 1) drive(w, 1'b0, 64'd0, 64'd0, 1'b0);
        check($sformatf("w%0d bp out_valid", w), 64'(get_ov(w)), 64'd1);
        check($sformatf("w%0d bp in_ready", w), 64'(get_ir(w)), 64'd0);
        check($sformatf("w%0d bp sum", w), get_sum(w), exp_sum);
        check($sformatf("w%0d bp cout", w), 64'(get_cout(w)), 64'(exp_cout));
      end
      set_rdy(w, 1'b1);
    end
    tick();
    check($sformatf("w%0d out_valid after release", w), 64'(get_ov(w)), 64'd0);
    check($sformatf("w%0d idle after release", w), 64'(get_ir(w)), 64'd1);
    check($sformatf("w%0d sum held in idle", w), get_sum(w), exp_sum);
    set_rdy(w, 1'b0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [63:0] ra, rb, bb_a[3], bb_b[3], bb_exp[3];
    logic        rc;
    logic [64:0] full;
    int          idx, res, last_acc;
    logic        acc;

    vecs.push_back('{8'h03, 8'h04, 1'b0, 8'h07, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h10, 8'h20, 1'b0, 8'h30, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 8'h01, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});

    drive(1, 1'b0, 64'd0, 64'd0, 1'b0); set_rdy(1, 1'b0);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0); set_rdy(8, 1'b0);
    drive(16, 1'b0, 64'd0, 64'd0, 1'b0); set_rdy(16, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset in_ready", 64'(ir8), 64'd1);
    check("reset out_valid", 64'(ov8), 64'd0);
    check("reset busy", 64'(bz8), 64'd0);
    check("reset sum", 64'(s8), 64'd0);
    check("reset cout", 64'(co8), 64'd0);
    check("reset sum w16", 64'(s16), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors, out_ready held high.
    foreach (vecs[i]) begin
      do_op(8, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].c, 64'(vecs[i].exp_sum),
            vecs[i].exp_cout, 1'b1, 0);
    end

    // Backpressure for 5 cycles with a rejected in_valid pulse during DONE.
    do_op(8, 64'h03, 64'h04, 1'b0, 64'h07, 1'b0, 1'b0, 5);

    // Reset in RUN at cnt = 3.
    drive(8, 1'b1, 64'h11, 64'h22, 1'b1);
    tick();
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (3) tick();
    check("pre-reset busy", 64'(bz8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset out_valid", 64'(ov8), 64'd0);
    check("mid-run reset busy", 64'(bz8), 64'd0);
    check("mid-run reset in_ready", 64'(ir8), 64'd1);
    check("mid-run reset sum", 64'(s8), 64'd0);
    tick();
    check("mid-run reset cout", 64'(co8), 64'd0);
    rst_n = 1'b1;
    tick();
    do_op(8, 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 1'b1, 0);

    // Back-to-back with in_valid and out_ready tied high.
    for (int i = 0; i < 3; i++) begin
      bb_a[i] = 64'($urandom_range(0, 255));
      bb_b[i] = 64'($urandom_range(0, 255));
      full = ref_add(8, bb_a[i], bb_b[i], 1'b0);
      bb_exp[i] = full[63:0] & 64'hFF;
    end
    set_rdy(8, 1'b1);
    drive(8, 1'b1, bb_a[0], bb_b[0], 1'b0);
    idx = 0; res = 0; last_acc = -1;
    for (int cyc = 0; cyc < 60 && res < 3; cyc++) begin
      acc = ir8 && iv8;
      if (ov8) begin
        check($sformatf("b2b sum %0d", res), 64'(s8), bb_exp[res]);
        res++;
      end
      tick();
      if (acc) begin
        if (idx > 0) check($sformatf("b2b spacing %0d", idx), 64'(cyc - last_acc), 64'd10);
        last_acc = cyc;
        idx++;
        if (idx < 3) drive(8, 1'b1, bb_a[idx], bb_b[idx], 1'b0);
        else drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
      end
    end
    check("b2b accepts", 64'(idx), 64'd3);
    check("b2b results", 64'(res), 64'd3);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    set_rdy(8, 1'b0);
    tick();

    // Random operations against the arithmetic model at WIDTH = 1 and 16.
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 1 : 16;
      repeat (200) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom);
        full = ref_add(w, ra, rb, rc);
        do_op(w, ra, rb, rc, full[63:0] & ((64'd1 << w) - 64'd1), full[w],
              1'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
